// File: rtl/noise_envelope_bank.sv
// noise_envelope_bank
//   N-channel noise generator for the discrete-sound section. A single shared
//   17-bit LFSR supplies every channel; each channel has its own sample-rate
//   divider, a retriggerable decaying envelope with loud/soft scaling, and a
//   registered signed PCM output feeding the audio mixer.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         asynchronous, active-high reset
//   clk_3MHz_en   1-cycle strobe, envelope prescaler tick
//   clk_24KHz_en  1-cycle strobe, LFSR/noise tick
//   sound_enable  global sound enable (freezes LFSR/envelopes, mutes outputs)
//   ch_en         per-channel trigger level, rising edge fires the envelope
//   ch_ls         per-channel loud(1)/soft(0)
//   ch_div        per-channel noise divisor, ch c at [c*DIV_W +: DIV_W]
//   ch_decay      per-channel decay rate, ch c at [c*DECAY_W +: DECAY_W]
//   noise_out     signed samples, ch c at [c*OUT_W +: OUT_W]
//   ch_busy       1 while the channel envelope is nonzero
module noise_envelope_bank #(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 4,
  parameter int DECAY_W = 8,
  parameter int ENV_W   = 8,
  parameter int OUT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_3MHz_en,
  input  logic                      clk_24KHz_en,
  input  logic                      sound_enable,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         ch_ls,
  input  logic [NUM_CH*DIV_W-1:0]   ch_div,
  input  logic [NUM_CH*DECAY_W-1:0] ch_decay,
  output logic [NUM_CH*OUT_W-1:0]   noise_out,
  output logic [NUM_CH-1:0]         ch_busy
);

  localparam int PRE_W = DECAY_W + 8;
  localparam int SHIFT = OUT_W - ENV_W - 1;

  logic [16:0]       lfsr;
  logic              noise_tick;
  logic              decay_tick;
  logic [NUM_CH-1:0] ch_en_d;
  logic [NUM_CH-1:0] fire;

  assign noise_tick = clk_24KHz_en & sound_enable;
  assign decay_tick = clk_3MHz_en & sound_enable;
  assign fire       = ch_en & ~ch_en_d & {NUM_CH{sound_enable}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 17'h1FFFF;
    end else if (noise_tick) begin
      if (lfsr == '0)
        lfsr <= 17'h00001;
      else
        lfsr <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
    end
  end

  // Edge detector keeps tracking while sound is disabled, so a level held
  // across a disable does not fire when sound comes back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ch_en_d <= '0;
    else
      ch_en_d <= ch_en;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int TAP = (5 * c) % 17;

    logic [DIV_W-1:0]   div;
    logic [DECAY_W-1:0] rate;
    logic [PRE_W-1:0]   pre_top;
    logic [DIV_W-1:0]   dcnt;
    logic               nbit;
    logic [ENV_W-1:0]   env;
    logic [PRE_W-1:0]   pre;
    logic [ENV_W-1:0]   amp;
    logic [OUT_W-1:0]   mag;
    logic [OUT_W-1:0]   out_q;
    logic               busy_q;

    assign div     = ch_div[c*DIV_W +: DIV_W];
    assign rate    = ch_decay[c*DECAY_W +: DECAY_W];
    assign pre_top = {rate, 8'hFF};

    // Samples the LFSR tap before this tick's shift.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dcnt <= '0;
        nbit <= 1'b0;
      end else if (noise_tick) begin
        if (dcnt == '0) begin
          dcnt <= div;
          nbit <= lfsr[TAP];
        end else begin
          dcnt <= dcnt - DIV_W'(1);
        end
      end
    end

    // Fire has priority over a coincident decay step.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        env <= '0;
        pre <= '0;
      end else if (fire[c]) begin
        env <= '1;
        pre <= '0;
      end else if (decay_tick && env != '0) begin
        if (pre == pre_top) begin
          pre <= '0;
          env <= env - ENV_W'(1);
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
    end

    always_comb begin
      amp = ch_ls[c] ? env : (env >> 2);
      mag = OUT_W'(amp) << SHIFT;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        busy_q <= (env != '0);
        if (!sound_enable)
          out_q <= '0;
        else if (nbit)
          out_q <= mag;
        else
          out_q <= '0 - mag;
      end
    end

    assign noise_out[c*OUT_W +: OUT_W] = out_q;
    assign ch_busy[c]                  = busy_q;
  end

endmodule

// File: tb/tb_noise_envelope_bank.sv
// Directed bench for noise_envelope_bank (NUM_CH=2, default widths).
module tb_noise_envelope_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_3MHz_en;
  logic        clk_24KHz_en;
  logic        sound_enable;
  logic [1:0]  ch_en;
  logic [1:0]  ch_ls;
  logic [7:0]  ch_div;
  logic [15:0] ch_decay;
  logic [31:0] noise_out;
  logic [1:0]  ch_busy;

  noise_envelope_bank #(
    .NUM_CH (2),
    .DIV_W  (4),
    .DECAY_W(8),
    .ENV_W  (8),
    .OUT_W  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_3MHz_en (clk_3MHz_en),
    .clk_24KHz_en(clk_24KHz_en),
    .sound_enable(sound_enable),
    .ch_en       (ch_en),
    .ch_ls       (ch_ls),
    .ch_div      (ch_div),
    .ch_decay    (ch_decay),
    .noise_out   (noise_out),
    .ch_busy     (ch_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference LFSR and sampled noise bits.
  logic [16:0] m_lfsr;
  bit          m_n0;
  bit          m_n1;

  typedef struct {
    bit         tick;
    logic [1:0] ls;
    bit         se;
    int         e0;
    int         e1;
    int         busy;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int o0();
    logic signed [15:0] s;
    s = noise_out[15:0];
    return int'(s);
  endfunction

  function automatic int o1();
    logic signed [15:0] s;
    s = noise_out[31:16];
    return int'(s);
  endfunction

  function automatic int eo(input int env, input bit nb, input bit ls);
    int mag;
    mag = ls ? env * 128 : (env / 4) * 128;
    if (env == 0) return 0;
    return nb ? mag : -mag;
  endfunction

  function automatic int env0_after(input int n);
    if (n >= 62976) return 255 - (n - 62976) / 256;
    return 255 - n / 256;
  endfunction

  function automatic int env1_after(input int n);
    if (n >= 65290) return 255 - (n - 65290) / 256;
    if (n >= 65280) return 0;
    return 255 - n / 256;
  endfunction

  task automatic cyc(input logic t3, input logic t24);
    clk_3MHz_en  = t3;
    clk_24KHz_en = t24;
    @(posedge clk);
    #1;
    clk_3MHz_en  = 1'b0;
    clk_24KHz_en = 1'b0;
  endtask

  // One noise tick with sound enabled; ch1 divisor is always 0.
  task automatic ntick(input bit samp0);
    cyc(1'b0, 1'b1);
    if (samp0) m_n0 = m_lfsr[0];
    m_n1   = m_lfsr[5];
    m_lfsr = {m_lfsr[15:0], m_lfsr[16] ^ m_lfsr[13]};
  endtask

  initial begin
    int e0;
    int e1;

    vt[0] = '{tick: 1'b1, ls: 2'b11, se: 1'b1, e0:  32640, e1: 32640, busy: 3};
    vt[1] = '{tick: 1'b0, ls: 2'b00, se: 1'b1, e0:   8064, e1:  8064, busy: 3};
    vt[2] = '{tick: 1'b0, ls: 2'b01, se: 1'b1, e0:  32640, e1:  8064, busy: 3};
    vt[3] = '{tick: 1'b0, ls: 2'b10, se: 1'b1, e0:   8064, e1: 32640, busy: 3};
    vt[4] = '{tick: 1'b0, ls: 2'b11, se: 1'b0, e0:      0, e1:     0, busy: 3};
    vt[5] = '{tick: 1'b1, ls: 2'b00, se: 1'b1, e0:  -8064, e1:  8064, busy: 3};
    vt[6] = '{tick: 1'b0, ls: 2'b11, se: 1'b1, e0: -32640, e1: 32640, busy: 3};

    reset        = 1'b1;
    clk_3MHz_en  = 1'b0;
    clk_24KHz_en = 1'b0;
    sound_enable = 1'b1;
    ch_en        = 2'b00;
    ch_ls        = 2'b11;
    ch_div       = 8'h00;
    ch_decay     = 16'h0000;
    m_lfsr       = 17'h1FFFF;
    m_n0         = 1'b0;
    m_n1         = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_out0", o0(), 0);
    chk("reset_out1", o1(), 0);
    chk("reset_busy", int'(ch_busy), 0);
    cyc(1'b0, 1'b0);
    chk("idle_busy", int'(ch_busy), 0);

    // Trigger both channels; noise bits are still 0 from reset.
    ch_en = 2'b11;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("trig_out0", o0(), -32640);
    chk("trig_out1", o1(), -32640);
    chk("trig_busy", int'(ch_busy), 3);

    // Loud/soft scaling, sign and mute table.
    for (int i = 0; i < 7; i++) begin
      ch_ls        = vt[i].ls;
      sound_enable = vt[i].se;
      if (vt[i].tick) ntick(1'b1);
      else            cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      chk($sformatf("vec%0d_out0", i), o0(), vt[i].e0);
      chk($sformatf("vec%0d_out1", i), o1(), vt[i].e1);
      chk($sformatf("vec%0d_busy", i), int'(ch_busy), vt[i].busy);
    end

    // LFSR sequence observed through both channels' sign (divisor 0).
    for (int k = 0; k < 28; k++) begin
      ntick(1'b1);
      cyc(1'b0, 1'b0);
      chk($sformatf("lfsr%0d_out0", k), o0(), eo(255, m_n0, 1'b1));
      chk($sformatf("lfsr%0d_out1", k), o1(), eo(255, m_n1, 1'b1));
    end

    // Sound disabled: LFSR and envelopes frozen even with both strobes.
    sound_enable = 1'b0;
    for (int k = 0; k < 50; k++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("mute_out0", o0(), 0);
    chk("mute_out1", o1(), 0);
    chk("mute_busy", int'(ch_busy), 3);
    sound_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ntick(1'b1);
      cyc(1'b0, 1'b0);
      chk($sformatf("hold%0d_out0", k), o0(), eo(255, m_n0, 1'b1));
      chk($sformatf("hold%0d_out1", k), o1(), eo(255, m_n1, 1'b1));
    end

    // ch0 divisor 3: new sample on ticks 1,5,9; ch1 every tick.
    ch_div = 8'h03;
    for (int k = 0; k < 12; k++) begin
      ntick(k % 4 == 0);
      cyc(1'b0, 1'b0);
      chk($sformatf("div%0d_out0", k), o0(), eo(255, m_n0, 1'b1));
      chk($sformatf("div%0d_out1", k), o1(), eo(255, m_n1, 1'b1));
    end

    // Decay with rate 0: ch0 falls to 10, retriggers on a decay step, ch1
    // decays to 0 then is retriggered on its own.
    for (int n = 1; n <= 65300; n++) begin
      if (n == 1000)  ch_en[0] = 1'b0;
      if (n == 62976) ch_en[0] = 1'b1;
      if (n == 65285) ch_en[1] = 1'b0;
      if (n == 65290) ch_en[1] = 1'b1;
      cyc(1'b1, 1'b0);
      e0 = env0_after(n - 1);
      e1 = env1_after(n - 1);
      chk($sformatf("dec%0d_out0", n), o0(), eo(e0, m_n0, 1'b1));
      chk($sformatf("dec%0d_out1", n), o1(), eo(e1, m_n1, 1'b1));
      chk($sformatf("dec%0d_busy", n), int'(ch_busy),
          ((e1 != 0) ? 2 : 0) + ((e0 != 0) ? 1 : 0));
    end

    // Asynchronous reset mid-decay, ch_en held high across it.
    #2 reset = 1'b1;
    #1;
    chk("areset_out0", o0(), 0);
    chk("areset_out1", o1(), 0);
    chk("areset_busy", int'(ch_busy), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_lfsr = 17'h1FFFF;
    m_n0   = 1'b0;
    m_n1   = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("postrst_out0", o0(), -32640);
    chk("postrst_out1", o1(), -32640);
    chk("postrst_busy", int'(ch_busy), 3);
    ntick(1'b1);
    cyc(1'b0, 1'b0);
    chk("postrst_lfsr_out0", o0(), 32640);
    chk("postrst_lfsr_out1", o1(), 32640);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
